// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink that checks an incrementing-data packet stream (exp = pkt_idx + beat_idx) plus length, tkeep and stall stability.
// Latency: counters, sticky flags and done update on the edge that accepts the triggering beat; tready is registered.
// Backpressure: tready follows cfg_ready_mode (always, never, LFSR random, alternating) in RECV and is low in IDLE/DONE.
//
// Ports:
//   aclk, areset                      clock, asynchronous active-high reset
//   s_axis_t{valid,ready,data,keep,last}  stream slave
//   enable                            rising edge in IDLE starts a run; falling edge ends/aborts it
//   cfg_len, cfg_num_pkts, cfg_ready_mode  run configuration, latched at start
//   pkt_count, err_count, err_flags   run statistics; flags [0]data [1]short [2]long [3]keep [4]protocol
//   first_err_pkt, first_err_beat     position of the first error in the run
//   done                              high while the run has completed and enable is still high
module axis_pkt_checker #(
    parameter int TDATA_WIDTH = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   enable,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    input  logic [CNT_WIDTH-1:0]   cfg_num_pkts,
    input  logic [1:0]             cfg_ready_mode,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic [4:0]             err_flags,
    output logic [CNT_WIDTH-1:0]   first_err_pkt,
    output logic [LEN_WIDTH-1:0]   first_err_beat,
    output logic                   done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DONE} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t                 state, state_next;
    logic                   tready_next;
    logic                   enable_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   num_pkts_q;
    logic [1:0]             mode_q;
    logic [15:0]            lfsr, lfsr_next;
    logic [LEN_WIDTH-1:0]   beat_idx;
    logic                   discard;
    logic                   stall_q;
    logic [TDATA_WIDTH-1:0] stall_dat;
    logic                   stall_last;

    logic                   start;
    logic                   accept;
    logic                   last_pkt;
    logic [LEN_WIDTH-1:0]   len_m1;
    logic [TDATA_WIDTH-1:0] exp_dat;
    logic [CNT_WIDTH-1:0]   pkt_count_inc;
    logic [4:0]             err_now;

    // pkt_count doubles as the packet index within the run.
    always_comb begin
        start         = (state == ST_IDLE) && enable && !enable_q;
        accept        = (state == ST_RECV) && s_axis_tvalid && s_axis_tready;
        len_m1        = len_q - LEN_WIDTH'(1);
        exp_dat       = TDATA_WIDTH'(pkt_count) + TDATA_WIDTH'(beat_idx);
        pkt_count_inc = (pkt_count == '1) ? pkt_count : pkt_count + CNT_WIDTH'(1);
        last_pkt      = accept && s_axis_tlast && (pkt_count_inc == num_pkts_q);
        lfsr_next     = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

        err_now = '0;
        if (accept) begin
            // Beats after an overlong packet's nominal end are only scanned for tlast.
            err_now[0] = !discard && (s_axis_tdata != exp_dat);
            err_now[1] = !discard && s_axis_tlast && (beat_idx < len_m1);
            err_now[2] = !discard && !s_axis_tlast && (beat_idx == len_m1);
            err_now[3] = !s_axis_tkeep;
        end
        // A stalled beat must be held unchanged until it is taken.
        if ((state != ST_IDLE) && stall_q &&
            (!s_axis_tvalid || (s_axis_tdata != stall_dat) || (s_axis_tlast != stall_last))) begin
            err_now[4] = 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        tready_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_RECV;
                    // Modes 0, 2 (seed bit 0 is 1) and 3 all open with tready high.
                    tready_next = (cfg_ready_mode != 2'd1);
                end
            end
            ST_RECV: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (last_pkt) begin
                    state_next = ST_DONE;
                end else begin
                    case (mode_q)
                        2'd0:    tready_next = 1'b1;
                        2'd1:    tready_next = 1'b0;
                        2'd2:    tready_next = lfsr_next[0];
                        default: tready_next = !s_axis_tready;
                    endcase
                end
            end
            ST_DONE: begin
                if (!enable) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign done = (state == ST_DONE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= ST_IDLE;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_next;
            s_axis_tready <= tready_next;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            enable_q       <= 1'b0;
            len_q          <= '0;
            num_pkts_q     <= '0;
            mode_q         <= '0;
            lfsr           <= LFSR_SEED;
            beat_idx       <= '0;
            discard        <= 1'b0;
            stall_q        <= 1'b0;
            stall_dat      <= '0;
            stall_last     <= 1'b0;
            pkt_count      <= '0;
            err_count      <= '0;
            err_flags      <= '0;
            first_err_pkt  <= '0;
            first_err_beat <= '0;
        end else begin
            enable_q   <= enable;
            stall_q    <= s_axis_tvalid && !s_axis_tready;
            stall_dat  <= s_axis_tdata;
            stall_last <= s_axis_tlast;

            if (start) begin
                len_q          <= cfg_len;
                num_pkts_q     <= cfg_num_pkts;
                mode_q         <= cfg_ready_mode;
                lfsr           <= LFSR_SEED;
                beat_idx       <= '0;
                discard        <= 1'b0;
                pkt_count      <= '0;
                err_count      <= '0;
                err_flags      <= '0;
                first_err_pkt  <= '0;
                first_err_beat <= '0;
            end else begin
                if (state == ST_RECV) lfsr <= lfsr_next;

                if (accept) begin
                    if (s_axis_tlast) begin
                        beat_idx  <= '0;
                        discard   <= 1'b0;
                        pkt_count <= pkt_count_inc;
                    end else if (err_now[2]) begin
                        discard <= 1'b1;
                    end else if (!discard) begin
                        beat_idx <= beat_idx + LEN_WIDTH'(1);
                    end
                end

                if (|err_now) begin
                    if (err_count == '0) begin
                        first_err_pkt  <= pkt_count;
                        first_err_beat <= beat_idx;
                    end
                    if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
                    err_flags <= err_flags | err_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_checker.sv
module tb_axis_pkt_checker;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tkeep;
    logic        s_axis_tlast;
    logic        enable;
    logic [15:0] cfg_len;
    logic [31:0] cfg_num_pkts;
    logic [1:0]  cfg_ready_mode;
    logic [31:0] pkt_count;
    logic [31:0] err_count;
    logic [4:0]  err_flags;
    logic [31:0] first_err_pkt;
    logic [15:0] first_err_beat;
    logic        done;

    axis_pkt_checker #(.TDATA_WIDTH(8), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .enable         (enable),
        .cfg_len        (cfg_len),
        .cfg_num_pkts   (cfg_num_pkts),
        .cfg_ready_mode (cfg_ready_mode),
        .pkt_count      (pkt_count),
        .err_count      (err_count),
        .err_flags      (err_flags),
        .first_err_pkt  (first_err_pkt),
        .first_err_beat (first_err_beat),
        .done           (done)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Reference LFSR used while a mode-2 run is in progress.
    logic [15:0] m_lfsr = 16'hACE1;
    bit          lfsr_on = 1'b0;
    int          lfsr_bad = 0;
    int          lfsr_cycles = 0;

    typedef struct {
        int               len;
        int               npk;
        logic [3:0][15:0] plen;     // beats actually sent per packet
        int               bad_idx;  // stream beat whose data is replaced (-1: none)
        logic [7:0]       bad_val;
        int               keep_idx; // stream beat sent with tkeep=0 (-1: none)
        int               e_pkts;
        int               e_errs;
        logic [4:0]       e_flags;
        int               e_fpkt;
        int               e_fbeat;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic cyc();
        @(negedge aclk);
        if (lfsr_on) begin
            m_lfsr = lfsr_step(m_lfsr);
            if (!done) begin
                lfsr_cycles++;
                if (s_axis_tready !== m_lfsr[0]) lfsr_bad++;
            end
        end
    endtask

    // Present one beat at a negedge and hold it until it has been taken.
    task automatic send(input logic [7:0] d, input logic l, input logic k);
        int t;
        t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tkeep  = k;
        while (s_axis_tready !== 1'b1 && t < 200) begin
            cyc();
            t++;
        end
        if (t >= 200) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: tready=%0b after 200 cycles, required 1", s_axis_tready);
        end
        cyc();
    endtask

    task automatic start_run(input logic [1:0] mode, input int len, input int n);
        s_axis_tvalid  = 1'b0;
        enable         = 1'b0;
        cyc();
        cyc();
        cfg_ready_mode = mode;
        cfg_len        = 16'(len);
        cfg_num_pkts   = 32'(n);
        enable         = 1'b1;
        cyc();
        chk("tready_first", s_axis_tready, (mode != 2'd1));
        chk("start_pkt_clear", pkt_count, 0);
        chk("start_err_clear", err_count, 0);
    endtask

    task automatic add(input int i, input int len, input int npk, input int l0, input int l1,
                       input int l2, input int bad_idx, input int bad_val, input int keep_idx,
                       input int pk, input int er, input int fl, input int fp, input int fb);
        vecs[i].len      = len;
        vecs[i].npk      = npk;
        vecs[i].plen     = {16'd0, 16'(l2), 16'(l1), 16'(l0)};
        vecs[i].bad_idx  = bad_idx;
        vecs[i].bad_val  = 8'(bad_val);
        vecs[i].keep_idx = keep_idx;
        vecs[i].e_pkts   = pk;
        vecs[i].e_errs   = er;
        vecs[i].e_flags  = 5'(fl);
        vecs[i].e_fpkt   = fp;
        vecs[i].e_fbeat  = fb;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int         idx;
        int         pl;
        logic [7:0] d;
        idx = 0;
        start_run(2'd0, v.len, v.npk);
        for (int p = 0; p < v.npk; p++) begin
            pl = int'(v.plen[p]);
            for (int b = 0; b < pl; b++) begin
                d = 8'(p + b);
                if (idx == v.bad_idx) d = v.bad_val;
                send(d, (b == pl - 1), (idx != v.keep_idx));
                idx++;
            end
        end
        s_axis_tvalid = 1'b0;
        chk($sformatf("v%0d_done", i), done, 1);
        chk($sformatf("v%0d_tready_after", i), s_axis_tready, 0);
        chk($sformatf("v%0d_pkt_count", i), pkt_count, 32'(v.e_pkts));
        chk($sformatf("v%0d_err_count", i), err_count, 32'(v.e_errs));
        chk($sformatf("v%0d_err_flags", i), err_flags, v.e_flags);
        chk($sformatf("v%0d_first_pkt", i), first_err_pkt, 32'(v.e_fpkt));
        chk($sformatf("v%0d_first_beat", i), first_err_beat, 16'(v.e_fbeat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //       i len npk  l0   l1   l2 bad  val  keep pk er fl fp fb
        add(0,   4,  3,   4,   4,   4, -1,   0,  -1, 3, 0, 0, 0, 0); // clean stream
        add(1,   4,  3,   4,   4,   4,  6,   5,  -1, 3, 1, 1, 1, 2); // pkt1 beat2 = 0x05
        add(2,   4,  2,   2,   4,   0, -1,   0,  -1, 2, 1, 2, 0, 1); // short packet
        add(3,   4,  2,   6,   4,   0, -1,   0,  -1, 2, 1, 4, 0, 3); // 6-beat long packet
        add(4,   4,  1,   4,   0,   0, -1,   0,   2, 1, 1, 8, 0, 2); // tkeep low on beat 2
        add(5,   4,  1,   4,   0,   0,  1, 'h55,  1, 1, 1, 9, 0, 1); // data+keep on one beat
        add(6,   3,  2,   3,   3,   0,  1, 'h99,  3, 2, 2, 9, 0, 1); // two errors, first kept
        add(7,   1,  3,   1,   1,   1, -1,   0,  -1, 3, 0, 0, 0, 0); // single-beat packets
        add(8, 260,  2, 260, 260,   0, -1,   0,  -1, 2, 0, 0, 0, 0); // data wraps 0xFF->0x00

        areset         = 1'b1;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = 8'h00;
        s_axis_tkeep   = 1'b1;
        s_axis_tlast   = 1'b0;
        enable         = 1'b0;
        cfg_len        = 16'd4;
        cfg_num_pkts   = 32'd1;
        cfg_ready_mode = 2'd0;
        #12;
        chk("reset_tready", s_axis_tready, 0);
        chk("reset_done", done, 0);
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_err_flags", err_flags, 0);
        @(negedge aclk);
        areset = 1'b0;
        cyc();

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Mode 2: tready must follow the LFSR from 0xACE1 across 100 packets.
        start_run(2'd2, 8, 100);
        m_lfsr  = 16'hACE1;
        lfsr_on = 1'b1;
        for (int p = 0; p < 100; p++)
            for (int b = 0; b < 8; b++)
                send(8'(p + b), (b == 7), 1'b1);
        lfsr_on = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("lfsr_mismatched_cycles", lfsr_bad, 0);
        chk("lfsr_cycles_covered", (lfsr_cycles >= 800), 1);
        chk("lfsr_pkt_count", pkt_count, 100);
        chk("lfsr_err_count", err_count, 0);
        chk("lfsr_done", done, 1);

        // Mode 1: stalled beat altered, then withdrawn.
        start_run(2'd1, 4, 1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = 1'b1;
        cyc();
        cyc();
        chk("proto_hold_clean", err_count, 0);
        s_axis_tdata = 8'h07;
        cyc();
        chk("proto_flag", err_flags, 5'b10000);
        chk("proto_err_count", err_count, 1);
        cyc();
        cyc();
        chk("proto_stable_after", err_count, 1);
        s_axis_tvalid = 1'b0;
        cyc();
        chk("proto_valid_drop", err_count, 2);
        chk("proto_pkt_count", pkt_count, 0);
        chk("proto_tready", s_axis_tready, 0);

        // Final tlast accepted on the same edge enable falls: counted, IDLE not DONE.
        start_run(2'd0, 2, 1);
        send(8'h00, 1'b0, 1'b1);
        s_axis_tdata  = 8'h01;
        s_axis_tlast  = 1'b1;
        enable        = 1'b0;
        cyc();
        s_axis_tvalid = 1'b0;
        chk("abort_pkt_count", pkt_count, 1);
        chk("abort_done", done, 0);
        chk("abort_tready", s_axis_tready, 0);
        cyc();
        chk("abort_done_later", done, 0);
        chk("abort_err_count", err_count, 0);

        // Asynchronous reset mid-packet (with an error already recorded), then a clean rerun.
        start_run(2'd0, 4, 3);
        send(8'h00, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        chk("pre_reset_err_count", err_count, 1);
        areset = 1'b1;
        #1;
        chk("areset_tready", s_axis_tready, 0);
        chk("areset_done", done, 0);
        chk("areset_pkt_count", pkt_count, 0);
        chk("areset_err_count", err_count, 0);
        chk("areset_err_flags", err_flags, 0);
        chk("areset_first_beat", first_err_beat, 0);
        @(negedge aclk);
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        run_vec(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_pkt_checker.md
# axis_pkt_checker

AXI4-Stream slave-side receiver and checker that terminates the output of the AXI stream FIFO (`AXI_FIFO`) in hardware. It replaces a slave VIP in self-checking benches and on-board loopback tests. It generates `tready` with a selectable backpressure pattern, checks every accepted beat against a deterministic incrementing-data packet format, and checks packet length, `tlast` placement and handshake stability. It reports counters and sticky error flags.

## Interface
Parameters:
- `TDATA_WIDTH`, 8: width of `s_axis_tdata`.
- `LEN_WIDTH`, 16: width of the packet-length config and the beat index.
- `CNT_WIDTH`, 32: width of the packet and error counters.

Ports:
- `aclk`  in  1  single clock; all logic on its rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tready`  out  1  stream ready; registered.
- `s_axis_tdata`  in  TDATA_WIDTH  stream data.
- `s_axis_tkeep`  in  1  byte enable; must be 1 on every beat.
- `s_axis_tlast`  in  1  end of packet.
- `enable`  in  1  level; a rising edge in IDLE starts a run.
- `cfg_len`  in  LEN_WIDTH  expected beats per packet, 1..2^LEN_WIDTH-1; sampled at start.
- `cfg_num_pkts`  in  CNT_WIDTH  packets per run, ≥1; sampled at start.
- `cfg_ready_mode`  in  2  0 = always ready, 1 = never ready, 2 = LFSR random, 3 = alternate 1/0; sampled at start.
- `pkt_count`  out  CNT_WIDTH  packets completed in this run.
- `err_count`  out  CNT_WIDTH  beats or packets that raised any error.
- `err_flags`  out  5  sticky: [0] data, [1] short, [2] long, [3] keep, [4] protocol.
- `first_err_pkt`  out  CNT_WIDTH  packet index of the first error.
- `first_err_beat`  out  LEN_WIDTH  beat index of the first error.
- `done`  out  1  high while in DONE.

## Operation
- Beat accept: `s_axis_tvalid & s_axis_tready` at a rising edge.
- Per-run state: `pkt_idx` counts packets and `beat_idx` is the beat index within the current packet.
- Expected data: `exp = pkt_idx[TDATA_WIDTH-1:0] + beat_idx`, truncated modulo 2^TDATA_WIDTH (wraps 0xFF→0x00).
- States:
  - IDLE: `tready` = 0. On `enable` 0→1: latch config; clear counters, flags and first-error captures; seed the LFSR; go to RECV.
  - RECV: accept and check beats. On an accepted `tlast` beat, `pkt_idx` increments and `beat_idx` returns to 0. When `pkt_idx` reaches `cfg_num_pkts`, go to DONE. If `enable` falls, abort to IDLE; counters and flags hold their values.
  - DONE: `tready` = 0, `done` = 1. When `enable` falls, go to IDLE.
- Checks on each accepted beat in RECV:
  - Data error: `tdata != exp`, while not in discard mode.
  - Short error: `tlast` = 1 with `beat_idx < cfg_len-1`. The packet ends there and is counted.
  - Long error: `tlast` = 0 with `beat_idx == cfg_len-1`. Enter discard mode; subsequent beats up to and including `tlast` are not data-checked. The packet is counted on `tlast`, then discard mode exits.
  - Keep error: `tkeep` = 0.
  - Protocol error: a stall cycle (`tvalid` = 1, `tready` = 0) followed by a cycle where `tvalid` dropped, or where `tdata`/`tlast` changed, without a handshake in between. This check is active in RECV and DONE.
- Error accounting:
  - `err_count` increments by exactly 1 per offending beat or stall violation, even if several flags set at once.
  - `first_err_*` are captured only when `err_count` is 0.
  - Counters saturate at all-ones.
- Ready generation, in RECV only:
  - Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1. It advances every RECV cycle; `tready_next` = lfsr[0].
  - Mode 3: `tready` toggles every cycle, starting at 1.

## Timing
- Reset values: `s_axis_tready` = 0, `done` = 0, all counters, flags and captures = 0, state = IDLE, LFSR = 0xACE1.
- `tready` is registered. It is 1 at the first RECV cycle in modes 0, 2 and 3.
- The final `tlast` acceptance drops `tready` in the very next cycle, so no beat is accepted after the last packet.
- Latency: `pkt_count`, `err_count`, `err_flags` and `done` update one cycle after the triggering handshake.
- Simultaneous accept of the final `tlast` and `enable` fall: the packet is counted and the block goes to IDLE, not DONE.
- `areset` asserted mid-packet: all outputs reach reset values asynchronously. There is no partial-packet accounting.

## Test plan
- Mode 0, `cfg_len`=4, `cfg_num_pkts`=3, correct stream 00 01 02 03 / 01 02 03 04 / 02 03 04 05 → `pkt_count`=3, `done`=1 one cycle after the last `tlast`, `err_flags`=0, `tready`=0 afterwards.
- Mode 2, `cfg_len`=8, 100 packets from the `AXI_FIFO` output → `pkt_count`=100, no errors, and `tready` shows the exact LFSR sequence from 0xACE1.
- Corrupt beat 2 of packet 1 (0x05 instead of 0x03), `cfg_len`=4 → `err_flags`[0]=1, `err_count`=1, `first_err_pkt`=1, `first_err_beat`=2.
- `tlast` on beat 1 with `cfg_len`=4 → short flag set; the next packet is checked starting from `exp` = `pkt_idx` with `beat_idx` 0. A 6-beat packet → long flag set, packet counted once at its `tlast`.
- Mode 1, `tvalid` held, then `tdata` changed 0x00→0x07 while stalled → `err_flags`[4]=1, `err_count`=1.
- `areset` pulsed mid-packet, then restarted via `enable` → all outputs 0 after reset, then clean counts on the next run.
